// File: rtl/alarm_timer_pkg.sv
// rtl/alarm_timer_pkg.sv - shared types and constants for the alarm timer bank
package alarm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } ch_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_timer_channel.sv
// rtl/alarm_timer_channel.sv - one timer channel: IDLE/RUN/PAUSE, one-shot or periodic terminal count
module alarm_timer_channel
    import alarm_timer_pkg::*;
#(
    parameter int CNT_W = 18
) (
    input  logic             clkSignal,
    input  logic             RST,
    input  logic             tick,
    input  logic             en,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             ld_mode,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] count
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             finish_q, finish_d;
    logic [CNT_W-1:0] counter_inc;

    always_ff @(posedge clkSignal or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            counter_q <= '0;
            limit_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            finish_q  <= finish_d;
        end
    end

    // Priority: stop, then load, then counting; a load therefore masks a terminal count.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        limit_d     = limit_q;
        mode_d      = mode_q;
        finish_d    = 1'b0;
        counter_inc = counter_q + CNT_W'(1);

        if (stop) begin
            state_d   = IDLE;
            counter_d = '0;
        end else if (load) begin
            state_d   = RUN;
            counter_d = '0;
            limit_d   = ld_val;
            mode_d    = ld_mode;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    if (!en) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (tick) begin
                            if (counter_inc == limit_q) begin
                                finish_d = 1'b1;
                                if (mode_q == MODE_PERIODIC) begin
                                    counter_d = '0;
                                end else begin
                                    counter_d = counter_inc;
                                    state_d   = IDLE;
                                end
                            end else begin
                                counter_d = counter_inc;
                            end
                        end
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q == RUN) || (state_q == PAUSE);
        finish = finish_q;
        count  = counter_q;
    end

endmodule

// File: rtl/alarm_timer_bank.sv
// rtl/alarm_timer_bank.sv - bank of N_CH alarm timers with shared load port; prescaler under ALARM_TIMER_PRESCALER_EN
module alarm_timer_bank
    import alarm_timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 18,
    parameter int PRE_W = 8
) (
    input  logic                      clkSignal,
    input  logic                      RST,
    input  logic [N_CH-1:0]           EN,
    input  logic [N_CH-1:0]           stop,
    input  logic                      ld,
    input  logic [ch_idx_w(N_CH)-1:0] ld_ch,
    input  logic [CNT_W-1:0]          ld_val,
    input  logic                      ld_mode,
`ifdef ALARM_TIMER_PRESCALER_EN
    input  logic [PRE_W-1:0]          prescale,
`endif
    output logic                      ld_ack,
    output logic                      ld_err,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           finish,
    output logic [N_CH*CNT_W-1:0]     count
);

    logic            ld_ack_q, ld_ack_d;
    logic            ld_err_q, ld_err_d;
    logic            ld_valid;
    logic [N_CH-1:0] load_vec;
    logic            tick;

    always_ff @(posedge clkSignal or posedge RST) begin
        if (RST) begin
            ld_ack_q <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            ld_ack_q <= ld_ack_d;
            ld_err_q <= ld_err_d;
        end
    end

    // A rejected load touches no channel; a stop on the target channel still lets ld_ack pulse.
    always_comb begin
        ld_valid = ld && (32'(ld_ch) < N_CH) && (ld_val != '0);
        ld_ack_d = ld_valid;
        ld_err_d = ld && !ld_valid;
        load_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            load_vec[i] = ld_valid && (32'(ld_ch) == i);
        end
    end

    assign ld_ack = ld_ack_q;
    assign ld_err = ld_err_q;

`ifdef ALARM_TIMER_PRESCALER_EN
    logic [PRE_W-1:0] pre_q, pre_d;

    always_ff @(posedge clkSignal or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // The >= compare resynchronises at once if prescale is lowered below the running phase.
    always_comb begin
        if (pre_q >= prescale) begin
            pre_d = '0;
            tick  = 1'b1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
            tick  = 1'b0;
        end
    end
`else
    logic [PRE_W-1:0] pre_unused;
    assign pre_unused = '0;
    assign tick       = 1'b1;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        alarm_timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clkSignal(clkSignal),
            .RST      (RST),
            .tick     (tick),
            .en       (EN[g]),
            .stop     (stop[g]),
            .load     (load_vec[g]),
            .ld_val   (ld_val),
            .ld_mode  (ld_mode),
            .busy     (busy[g]),
            .finish   (finish[g]),
            .count    (count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/alarm_timer_bank.md
ALARM_TIMER_BANK -- requirements
Module: alarm_timer_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-002 Parameter CNT_W, default 18, width of terminal count and per-channel counter.
REQ-003 Parameter PRE_W, default 8, width of shared prescaler divisor; used only with ALARM_TIMER_PRESCALER_EN.
REQ-004 clkSignal  input  1  clock; every register updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 EN  input  N_CH  per-channel count enable; low pauses that channel.
REQ-007 stop  input  N_CH  per-channel stop strobe; forces the channel to IDLE.
REQ-008 ld  input  1  load strobe; each cycle sampled high is one load request.
REQ-009 ld_ch  input  clog2(N_CH), min 1  target channel of the load.
REQ-010 ld_val  input  CNT_W  terminal count M.
REQ-011 ld_mode  input  1  0 = one-shot, 1 = periodic.
REQ-012 prescale  input  PRE_W  tick divisor; present only with ALARM_TIMER_PRESCALER_EN.
REQ-013 ld_ack  output  1  one-cycle pulse, load accepted.
REQ-014 ld_err  output  1  one-cycle pulse, load rejected.
REQ-015 busy  output  N_CH  channel in RUN or PAUSE.
REQ-016 finish  output  N_CH  one-cycle pulse at terminal count.
REQ-017 count  output  N_CH*CNT_W  current counter of each channel, channel 0 in LSBs.

Function
REQ-018 Each channel SHALL implement states IDLE, RUN, PAUSE.
REQ-019 A valid load (ld=1, ld_ch<N_CH, ld_val!=0) SHALL, at the next edge, set counter=0, latch M and mode, enter RUN, and pulse ld_ack.
REQ-020 A load with ld_val=0 or ld_ch>=N_CH SHALL change no channel state and pulse ld_err at the next edge instead of ld_ack.
REQ-021 A load to a channel in RUN or PAUSE SHALL restart it from 0 with the new M and mode.
REQ-022 In RUN with EN[i]=1, the counter SHALL increment by 1 on each tick.
REQ-023 When an increment makes counter==M, finish[i] SHALL be high for exactly the following clock cycle.
REQ-024 At terminal count, a one-shot channel SHALL go to IDLE with counter held at M; a periodic channel SHALL reload counter=0 and stay in RUN, giving one finish pulse per M ticks.
REQ-025 EN[i]=0 in RUN SHALL move the channel to PAUSE with the counter held and no finish; EN[i]=1 SHALL return it to RUN on the next edge.
REQ-026 stop[i]=1 SHALL force IDLE with counter=0 at the next edge; stop and load on the same channel in one cycle: stop wins, ld_ack still pulses.
REQ-027 A load coinciding with terminal count on the same channel SHALL win; no finish pulse for that cycle.
REQ-028 Counter arithmetic SHALL be unsigned CNT_W bits; the counter never exceeds M and never wraps.
REQ-029 busy[i] SHALL be high in RUN or PAUSE.

Reset
REQ-030 RST=1 SHALL immediately force all channels to IDLE, all counters and latched M to 0, the prescaler to 0, and ld_ack, ld_err, finish, busy, count to 0.
REQ-031 RST asserted mid-count SHALL discard all pending loads and finish pulses; no output pulses in the first cycle after release.

Configuration
REQ-032 With macro ALARM_TIMER_PRESCALER_EN defined: a shared free-running PRE_W-bit prescaler SHALL produce one tick every prescale+1 clocks, with prescale=0 giving a tick every clock.
REQ-033 Without ALARM_TIMER_PRESCALER_EN: the prescale port and prescaler logic SHALL be absent and every clock SHALL be a tick.

Structure
REQ-034 Package alarm_timer_pkg SHALL hold the channel state enum (IDLE, RUN, PAUSE) and mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
REQ-035 Per-channel logic SHALL be sub-module alarm_timer_channel, instantiated N_CH times by a generate loop; the prescaler and load decode stay in the top level.

Verification
REQ-036 Load ch0, M=5, one-shot, EN=1, no prescaler -> ld_ack next cycle; finish[0] exactly once, 5 clocks after ld_ack; busy[0] then 0; count[0]=5.
REQ-037 Load ch2, M=3, periodic -> finish[2] pulses every 3 clocks; stop[2] -> busy[2]=0, count=0, no further pulses.
REQ-038 Load ch1, M=10; drop EN[1] for 4 cycles at count=6 -> count holds 6; finish arrives 4 cycles late.
REQ-039 Loads with ld_val=0 and ld_ch=N_CH -> ld_err pulse each; no busy change on any channel.
REQ-040 With ALARM_TIMER_PRESCALER_EN, prescale=3, M=2 -> finish 8 clocks after load ±3 for prescaler phase; RST mid-count -> all outputs 0 immediately.
REQ-041 Periodic M=4 with a reload M=2 on the terminal-count cycle -> no finish that cycle; next finish 2 ticks later.
